// File: rtl/decode_stage.sv
// RV32I(M) decode stage with an ID/EX register, valid/ready handshake,
// flush, load-use bubble insertion and illegal-instruction flagging.
module decode_stage #(
  parameter int ENABLE_M         = 1,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int PC_W             = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_alu_opt,
  output logic            out_alu_a_sel,
  output logic [1:0]      out_alu_b_sel,
  output logic            out_write_reg_enable,
  output logic [1:0]      out_write_ram_flag,
  output logic [2:0]      out_read_ram_flag,
  output logic            out_wb_sel,
  output logic [1:0]      out_pc_condition,
  output logic            out_illegal
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3,  ALU_XOR  = 5'd4,  ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7,  ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9,  ALU_JALR = 5'd10, ALU_BEQ = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd17, ALU_MUL  = 5'd18;

  localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  alu_opt;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic        wen;
    logic [1:0]  wram;
    logic [2:0]  rram;
    logic        wb_sel;
    logic [1:0]  pcc;
    logic        illegal;
    logic        use_rs1;
    logic        use_rs2;
  } dec_t;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t        dec;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec         = '0;
    dec.use_rs1 = 1'b1;
    case (opcode)
      OP_LUI:   begin dec.imm = imm_u; dec.alu_opt = ALU_LUI; dec.b_sel = 2'b01; dec.wen = 1'b1; dec.use_rs1 = 1'b0; end
      OP_AUIPC: begin dec.imm = imm_u; dec.a_sel = 1'b1; dec.b_sel = 2'b01; dec.wen = 1'b1; dec.use_rs1 = 1'b0; end
      OP_JAL:   begin dec.imm = imm_j; dec.a_sel = 1'b1; dec.b_sel = 2'b11; dec.wen = 1'b1; dec.pcc = 2'b10; dec.use_rs1 = 1'b0; end
      OP_JALR:  begin dec.imm = imm_i; dec.alu_opt = ALU_JALR; dec.b_sel = 2'b01; dec.wen = 1'b1; dec.pcc = 2'b11; end
      OP_LOAD: begin
        dec.imm = imm_i; dec.b_sel = 2'b01; dec.wen = 1'b1; dec.wb_sel = 1'b1;
        case (f3)
          3'b000:  dec.rram = 3'b111;
          3'b001:  dec.rram = 3'b110;
          3'b010:  dec.rram = 3'b001;
          3'b100:  dec.rram = 3'b011;
          3'b101:  dec.rram = 3'b010;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.imm = imm_s; dec.b_sel = 2'b01; dec.use_rs2 = 1'b1;
        case (f3)
          3'b010:  dec.wram = 2'b01;
          3'b001:  dec.wram = 2'b10;
          3'b000:  dec.wram = 2'b11;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.pcc = 2'b01; dec.use_rs2 = 1'b1;
        case (f3)
          3'b000, 3'b001: dec.alu_opt = ALU_BEQ + {4'b0, f3[0]};
          3'b010, 3'b011: dec.illegal = 1'b1;
          default:        dec.alu_opt = ALU_BEQ + {2'b0, f3} - 5'd2;
        endcase
      end
      OP_IMM, OP_REG: begin
        dec.wen = 1'b1;
        if (opcode == OP_IMM) begin
          dec.imm = imm_i; dec.b_sel = 2'b01;
        end else begin
          dec.use_rs2 = 1'b1;
        end
        case (f3)
          3'b000:  dec.alu_opt = ALU_ADD;
          3'b001:  dec.alu_opt = ALU_SLL;
          3'b010:  dec.alu_opt = ALU_SLT;
          3'b011:  dec.alu_opt = ALU_SLTU;
          3'b100:  dec.alu_opt = ALU_XOR;
          3'b101:  dec.alu_opt = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_opt = ALU_OR;
          default: dec.alu_opt = ALU_AND;
        endcase
        // Register-form: the alternate func7 only exists for sub/sra; 0000001 selects M.
        if (opcode == OP_REG) begin
          if (f7 == 7'b0100000 && f3 == 3'b000) dec.alu_opt = ALU_SUB;
          else if (f7 == 7'b0000001 && ENABLE_M != 0) dec.alu_opt = ALU_MUL + {2'b0, f3};
          else if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b101))) dec.illegal = 1'b1;
        end else if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                     (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.wen  = 1'b0;
      dec.wram = 2'b00;
      dec.rram = 3'b000;
      dec.pcc  = 2'b00;
    end
  end

  logic [1:0] state, stall_cnt, age, hz_cnt;
  logic [4:0] ld_rd, hz_rd;
  logic       accept, xfer, load_xfer, dep, need_stall;

  assign out_valid  = !rst && !flush && (state == S_FULL);
  assign in_ready   = !rst && !flush && ((state == S_EMPTY) || (state == S_FULL && out_ready));
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign load_xfer  = xfer && (out_read_ram_flag != 3'b000) && (out_rd != 5'd0);

  // A load leaving on this very edge is not yet in ld_rd, so compare against it directly.
  assign hz_rd      = load_xfer ? out_rd : ld_rd;
  assign hz_cnt     = load_xfer ? BUBBLES : age;
  assign dep        = (dec.use_rs1 && rs1 != 5'd0 && rs1 == hz_rd) ||
                      (dec.use_rs2 && rs2 != 5'd0 && rs2 == hz_rd);
  assign need_stall = dep && (hz_cnt != 2'd0);

  // NOTE: the ID/EX payload is reset too, so EX sees all-zero fields straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY; stall_cnt <= '0; age <= '0; ld_rd <= '0;
      out_pc <= '0; out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0; out_imm <= '0;
      out_alu_opt <= '0; out_alu_a_sel <= 1'b0; out_alu_b_sel <= '0;
      out_write_reg_enable <= 1'b0; out_write_ram_flag <= '0; out_read_ram_flag <= '0;
      out_wb_sel <= 1'b0; out_pc_condition <= '0; out_illegal <= 1'b0;
    end else if (flush) begin
      state <= S_EMPTY; stall_cnt <= '0; age <= '0;
    end else begin
      if (load_xfer) begin
        age   <= BUBBLES;
        ld_rd <= out_rd;
      end else if (age != 2'd0) begin
        age <= age - 2'd1;
      end
      if (accept) begin
        state     <= need_stall ? S_STALL : S_FULL;
        stall_cnt <= need_stall ? hz_cnt : 2'd0;
        out_pc <= in_pc; out_rs1 <= rs1; out_rs2 <= rs2; out_rd <= rd; out_imm <= dec.imm;
        out_alu_opt <= dec.alu_opt; out_alu_a_sel <= dec.a_sel; out_alu_b_sel <= dec.b_sel;
        out_write_reg_enable <= dec.wen; out_write_ram_flag <= dec.wram;
        out_read_ram_flag <= dec.rram; out_wb_sel <= dec.wb_sel;
        out_pc_condition <= dec.pcc; out_illegal <= dec.illegal;
      end else begin
        case (state)
          S_EMPTY: state <= S_EMPTY;
          S_FULL:  if (xfer) state <= S_EMPTY;
          S_STALL: begin
            if (stall_cnt <= 2'd1) begin
              state     <= S_FULL;
              stall_cnt <= 2'd0;
            end else begin
              stall_cnt <= stall_cnt - 2'd1;
            end
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed handshake/hazard/flush/illegal
// steps, then random traffic scored against a table-driven decode model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_alu_a_sel, out_write_reg_enable, out_wb_sel, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_opt;
  logic [1:0]  out_alu_b_sel, out_write_ram_flag, out_pc_condition;
  logic [2:0]  out_read_ram_flag;

  logic        nm_in_ready, nm_out_valid, nm_a_sel, nm_wen, nm_wb_sel, nm_illegal;
  logic [31:0] nm_pc, nm_imm;
  logic [4:0]  nm_rs1, nm_rs2, nm_rd, nm_alu;
  logic [1:0]  nm_b_sel, nm_wram, nm_pcc;
  logic [2:0]  nm_rram;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(1), .LOAD_USE_BUBBLES(1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_opt(out_alu_opt), .out_alu_a_sel(out_alu_a_sel), .out_alu_b_sel(out_alu_b_sel),
    .out_write_reg_enable(out_write_reg_enable), .out_write_ram_flag(out_write_ram_flag),
    .out_read_ram_flag(out_read_ram_flag), .out_wb_sel(out_wb_sel),
    .out_pc_condition(out_pc_condition), .out_illegal(out_illegal)
  );

  decode_stage #(.ENABLE_M(0), .LOAD_USE_BUBBLES(1), .PC_W(32)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_pc(nm_pc), .out_rs1(nm_rs1), .out_rs2(nm_rs2), .out_rd(nm_rd), .out_imm(nm_imm),
    .out_alu_opt(nm_alu), .out_alu_a_sel(nm_a_sel), .out_alu_b_sel(nm_b_sel),
    .out_write_reg_enable(nm_wen), .out_write_ram_flag(nm_wram),
    .out_read_ram_flag(nm_rram), .out_wb_sel(nm_wb_sel),
    .out_pc_condition(nm_pcc), .out_illegal(nm_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        a;
    logic [1:0]  b;
    logic        wen;
    logic [1:0]  wram;
    logic [2:0]  rram;
    logic        wb;
    logic [1:0]  pcc;
    logic        ill;
  } rec_t;

  // ALU code of the base integer op selected by func3 (add,sll,slt,sltu,xor,srl,or,and).
  localparam int BASE_ALU [8] = '{0, 5, 6, 7, 4, 8, 3, 2};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t model(input logic [31:0] w, input logic [31:0] pc, input bit m_en);
    rec_t               r;
    logic signed [31:0] s;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j, sgn;
    s     = w;
    f3    = w[14:12];
    f7    = w[31:25];
    sgn   = 32'(s >>> 31);
    imm_i = 32'(s >>> 20);
    imm_s = (32'(s >>> 25) << 5) | {27'd0, w[11:7]};
    imm_b = (sgn << 12) | {20'd0, w[7], 11'd0} | {21'd0, w[30:25], 5'd0} | {27'd0, w[11:8], 1'b0};
    imm_u = w & 32'hFFFF_F000;
    imm_j = (sgn << 20) | {12'd0, w[19:12], 12'd0} | {20'd0, w[20], 11'd0} | {21'd0, w[30:21], 1'b0};
    r     = '0;
    r.pc  = pc;
    r.rs1 = w[19:15];
    r.rs2 = w[24:20];
    r.rd  = w[11:7];
    case (w[6:0])
      7'h37: begin r.imm = imm_u; r.alu = 5'd17; r.b = 2'd1; r.wen = 1'b1; end
      7'h17: begin r.imm = imm_u; r.a = 1'b1; r.b = 2'd1; r.wen = 1'b1; end
      7'h6F: begin r.imm = imm_j; r.a = 1'b1; r.b = 2'd3; r.wen = 1'b1; r.pcc = 2'd2; end
      7'h67: begin r.imm = imm_i; r.alu = 5'd10; r.b = 2'd1; r.wen = 1'b1; r.pcc = 2'd3; end
      7'h03: begin
        r.imm = imm_i; r.b = 2'd1; r.wen = 1'b1; r.wb = 1'b1;
        if      (f3 == 3'd0) r.rram = 3'b111;
        else if (f3 == 3'd1) r.rram = 3'b110;
        else if (f3 == 3'd2) r.rram = 3'b001;
        else if (f3 == 3'd4) r.rram = 3'b011;
        else if (f3 == 3'd5) r.rram = 3'b010;
        else r.ill = 1'b1;
      end
      7'h23: begin
        r.imm = imm_s; r.b = 2'd1;
        if      (f3 == 3'd2) r.wram = 2'b01;
        else if (f3 == 3'd1) r.wram = 2'b10;
        else if (f3 == 3'd0) r.wram = 2'b11;
        else r.ill = 1'b1;
      end
      7'h63: begin
        r.imm = imm_b; r.pcc = 2'd1;
        if (f3 == 3'd2 || f3 == 3'd3) r.ill = 1'b1;
        else r.alu = 5'(11 + ((f3 >= 3'd4) ? int'(f3) - 2 : int'(f3)));
      end
      7'h13: begin
        r.imm = imm_i; r.b = 2'd1; r.wen = 1'b1; r.alu = 5'(BASE_ALU[f3]);
        if (f3 == 3'd1 && f7 != 7'd0) r.ill = 1'b1;
        if (f3 == 3'd5 && f7 == 7'h20) r.alu = 5'd9;
        else if (f3 == 3'd5 && f7 != 7'd0) r.ill = 1'b1;
      end
      7'h33: begin
        r.wen = 1'b1;
        if (f7 == 7'd0) r.alu = 5'(BASE_ALU[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 5'd9;
        else if (f7 == 7'h01 && m_en) r.alu = 5'(18 + int'(f3));
        else r.ill = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin
      r.wen = 1'b0; r.wram = 2'b00; r.rram = 3'b000; r.pcc = 2'b00;
    end
    return r;
  endfunction

  // Operand fields of an illegal instruction carry no meaning; only the flags are compared.
  function automatic rec_t canon(input rec_t r);
    rec_t c = r;
    if (c.ill) begin
      c.imm = '0; c.alu = '0; c.a = 1'b0; c.b = '0; c.wb = 1'b0;
    end
    return c;
  endfunction

  function automatic rec_t obs();
    rec_t r;
    r = '{out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_opt, out_alu_a_sel, out_alu_b_sel,
          out_write_reg_enable, out_write_ram_flag, out_read_ram_flag, out_wb_sel,
          out_pc_condition, out_illegal};
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r;
    int          k, j;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom);
    r   = $urandom;
    k   = int'($urandom_range(0, 10));
    j   = int'($urandom_range(0, 3));
    f7  = (j == 0) ? 7'h00 : (j == 1) ? 7'h20 : (j == 2) ? 7'h01 : r[6:0];
    case (k)
      0:       return {r[31:12], rd, 7'h37};
      1:       return {r[31:12], rd, 7'h17};
      2:       return {r[31:12], rd, 7'h6F};
      3:       return {r[31:20], rs1, 3'b000, rd, 7'h67};
      4:       return {r[31:20], rs1, f3, rd, 7'h03};
      5:       return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
      6:       return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      7:       return {f7, r[24:20], rs1, f3, rd, 7'h13};
      8, 9:    return {f7, rs2, rs1, f3, rd, 7'h33};
      default: return r;
    endcase
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input string tag);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, 128'(got), 128'(1'b1));
  endtask

  // Streams a then b (with `idle` empty cycles between them) at out_ready = 1 and checks
  // both records plus the number of out_valid-low cycles between their transfers.
  task automatic pair_gap(input logic [31:0] a, input logic [31:0] b, input int idle,
                          input int exp_gap, input string tag);
    int   stage, idle_left, t_a, t_b;
    logic acc;
    stage = 0; idle_left = idle; t_a = -1; t_b = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && t_b < 0; c++) begin
      if (stage == 1 && idle_left == 0) stage = 2;
      in_valid = (stage == 0 || stage == 2);
      in_instr = (stage == 0) ? a : b;
      in_pc    = (stage == 0) ? 32'h100 : 32'h104;
      #1;
      if (out_valid) begin
        if (t_a < 0) begin
          check({tag, "_a"}, 128'(canon(obs())), 128'(canon(model(a, 32'h100, 1'b1))));
          t_a = c;
        end else begin
          check({tag, "_b"}, 128'(canon(obs())), 128'(canon(model(b, 32'h104, 1'b1))));
          t_b = c;
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (stage == 1) idle_left--;
      if (acc) stage++;
    end
    in_valid = 1'b0;
    check({tag, "_gap"}, 128'(t_b - t_a - 1), 128'(exp_gap));
  endtask

  rec_t        exp_q[$];
  logic [31:0] pc_ctr;
  logic        acc, xf;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h0050_0093; in_pc = 32'h0;
    tick();
    #1;
    check("rst_handshake", 128'({in_ready, out_valid}), 128'(2'b00));
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_outputs", 128'(obs()), 128'(0));
    check("rst_idle_ready", 128'({in_ready, out_valid}), 128'(2'b10));
    tick();

    // addi then dependent add: no load involved, back-to-back.
    pair_gap(32'h0050_0093, 32'h0010_8133, 0, 0, "addi_add");
    // lw x5 followed by a user of x5 costs one bubble; an unrelated reader costs none.
    pair_gap(32'h0000_A283, 32'h0002_8333, 0, 1, "ld_use");
    pair_gap(32'h0000_A283, 32'h0003_8333, 0, 0, "ld_nouse");
    pair_gap(32'h0000_A283, 32'h0002_8333, 2, 2, "ld_aged");

    // Back-pressure while holding jal x1,16.
    out_ready = 1'b0;
    send(32'h0100_00EF, 32'h300, "jal");
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", 128'({in_ready, out_valid}), 128'(2'b01));
      check("hold_fields", 128'({out_pc, out_imm, out_pc_condition, out_alu_b_sel}),
            128'({32'h300, 32'd16, 2'b10, 2'b11}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release", 128'({in_ready, out_valid}), 128'(2'b11));
    tick();
    in_valid = 1'b0;
    #1;
    check("after_release_pc", 128'({out_valid, out_pc}), 128'({1'b1, 32'h304}));
    tick();

    // Flush while a dependent add is stalled behind lw x5.
    send(32'h0000_A283, 32'h200, "flush_lw");
    in_valid = 1'b1; in_instr = 32'h0002_8333; in_pc = 32'h204;
    #1;
    check("stall_entry_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush_gate", 128'({in_ready, out_valid}), 128'(2'b00));
    tick();
    flush = 1'b0;
    #1;
    check("post_flush_empty", 128'({in_ready, out_valid}), 128'(2'b10));
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("flushed_gone", 128'(out_valid), 128'(1'b0));
    end
    tick();

    // mul x3,x1,x2 with and without the M extension.
    send(32'h0220_81B3, 32'h400, "mul");
    #1;
    check("mul_m", 128'({out_alu_opt, out_illegal, out_write_reg_enable}), 128'({5'b10010, 1'b0, 1'b1}));
    check("mul_nom", 128'({nm_illegal, nm_wen}), 128'(2'b10));

    // Unknown opcode and srai with a bad func7.
    send(32'h0000_007F, 32'h404, "op7f");
    #1;
    check("op7f_flags", 128'({out_illegal, out_write_reg_enable, out_write_ram_flag, out_read_ram_flag, out_pc_condition}),
          128'({1'b1, 8'd0}));
    send(32'h0231_5093, 32'h408, "srai_bad");
    #1;
    check("srai_flags", 128'({out_illegal, out_write_reg_enable, out_write_ram_flag, out_read_ram_flag, out_pc_condition}),
          128'({1'b1, 8'd0}));
    tick();

    // Random traffic with back-pressure and occasional flushes.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_ctr = 32'h1000;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = pc_ctr;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (flush) begin
        check("rnd_flush_gate", 128'({in_ready, out_valid}), 128'(2'b00));
        exp_q.delete();
      end else begin
        if (out_valid) check("rnd_held", 128'(exp_q.size()), 128'(1));
        if (out_valid && !out_ready) check("rnd_backpressure", 128'(in_ready), 128'(1'b0));
        if (xf && exp_q.size() != 0) begin
          check("rnd_xfer", 128'(canon(obs())), 128'(canon(exp_q[0])));
          void'(exp_q.pop_front());
        end
      end
      if (acc) begin
        exp_q.push_back(model(in_instr, in_pc, 1'b1));
        pc_ctr = pc_ctr + 32'd4;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
